// File: rtl/mat_mul_simd_seq.sv
`default_nettype none
//============================================================================
// mat_mul_simd_seq : sequential SIMD signed matrix multiplier, C = A x B
// Option macro: MAT_MUL_SAT_EN (saturating narrowing)        | Rev 1.0
//============================================================================
module mat_mul_simd_seq #(
   parameter int W_IN       = 8,
   parameter int W_OUT      = 32,
   parameter int N          = 2,
   parameter int SIMD_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cen,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic signed [W_IN-1:0]  matrix_1 [N][N],
   input  logic signed [W_IN-1:0]  matrix_2 [N][N],
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic signed [W_OUT-1:0] result [N][N],
   output logic                    busy
);

   localparam int c_w_acc = 2*W_IN + $clog2(N) + 1;
   localparam int c_nn    = N*N;
   localparam int c_g     = (c_nn + SIMD_WIDTH - 1) / SIMD_WIDTH;
   localparam int c_iw    = (N > 1) ? $clog2(N) : 1;
   localparam int c_gw    = (c_g > 1) ? $clog2(c_g) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                    r_state;
   logic [c_gw-1:0]           r_grp;
   logic [c_iw-1:0]           r_k;
   logic signed [W_IN-1:0]    r_a   [N][N];
   logic signed [W_IN-1:0]    r_b   [N][N];
   logic signed [c_w_acc-1:0] r_acc [SIMD_WIDTH];

   int                        w_elem   [SIMD_WIDTH];
   logic                      w_active [SIMD_WIDTH];
   logic [c_iw-1:0]           w_row    [SIMD_WIDTH];
   logic [c_iw-1:0]           w_col    [SIMD_WIDTH];
   logic signed [c_w_acc-1:0] w_prod   [SIMD_WIDTH];
   logic signed [c_w_acc-1:0] w_sum    [SIMD_WIDTH];
   logic signed [W_OUT-1:0]   w_narrow [SIMD_WIDTH];
   logic                      w_accept;
   logic                      w_last_k;
   logic                      w_last_grp;

   assign ready_in   = (r_state == S_IDLE) || ((r_state == S_DONE) && ready_out);
   assign w_accept   = valid_in && ready_in;
   assign w_last_k   = (r_k == c_iw'(N-1));
   assign w_last_grp = (r_grp == c_gw'(c_g-1));

   // Each lane owns one output element per group; lanes past N*N stay idle.
   generate
      for (genvar l = 0; l < SIMD_WIDTH; l++) begin : g_lane
         assign w_elem[l]   = int'(r_grp) * SIMD_WIDTH + l;
         assign w_active[l] = (w_elem[l] < c_nn);
         assign w_row[l]    = w_active[l] ? c_iw'(w_elem[l] / N) : '0;
         assign w_col[l]    = w_active[l] ? c_iw'(w_elem[l] % N) : '0;
         assign w_prod[l]   = c_w_acc'(r_a[w_row[l]][r_k]) * c_w_acc'(r_b[r_k][w_col[l]]);
         assign w_sum[l]    = r_acc[l] + w_prod[l];

         if (W_OUT >= c_w_acc) begin : g_wide
            assign w_narrow[l] = W_OUT'(w_sum[l]);
         end else begin : g_narrow
`ifdef MAT_MUL_SAT_EN
            localparam logic signed [c_w_acc-1:0] c_max =
               {{(c_w_acc-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
            localparam logic signed [c_w_acc-1:0] c_min =
               {{(c_w_acc-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
            assign w_narrow[l] = (w_sum[l] > c_max) ? {1'b0, {(W_OUT-1){1'b1}}} :
                                 (w_sum[l] < c_min) ? {1'b1, {(W_OUT-1){1'b0}}} :
                                 w_sum[l][W_OUT-1:0];
`else
            assign w_narrow[l] = w_sum[l][W_OUT-1:0];
`endif
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         valid_out <= 1'b0;
         busy      <= 1'b0;
         r_grp     <= '0;
         r_k       <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               result[i][j] <= '0;
               r_a[i][j]    <= '0;
               r_b[i][j]    <= '0;
            end
         end
         for (int l = 0; l < SIMD_WIDTH; l++) r_acc[l] <= '0;
      end else if (cen) begin
         case (r_state)
            S_COMPUTE: begin
               for (int l = 0; l < SIMD_WIDTH; l++) begin
                  if (w_active[l]) begin
                     if (w_last_k) begin
                        result[w_row[l]][w_col[l]] <= w_narrow[l];
                        r_acc[l]                   <= '0;
                     end else begin
                        r_acc[l] <= w_sum[l];
                     end
                  end
               end
               if (w_last_k) begin
                  r_k <= '0;
                  if (w_last_grp) begin
                     r_grp     <= '0;
                     r_state   <= S_DONE;
                     valid_out <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     r_grp <= r_grp + 1'b1;
                  end
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_DONE: begin
               if (ready_out) begin
                  valid_out <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: ;
         endcase

         // A new job overrides the IDLE/DONE transitions above (back-to-back accept).
         if (w_accept) begin
            r_a     <= matrix_1;
            r_b     <= matrix_2;
            r_state <= S_COMPUTE;
            r_grp   <= '0;
            r_k     <= '0;
            busy    <= 1'b1;
            for (int l = 0; l < SIMD_WIDTH; l++) r_acc[l] <= '0;
         end
      end
   end

endmodule
`default_nettype wire
